// File: rtl/simplez_mem_pkg.sv
// Shared constants and types for the Simplez memory arbiter.
package simplez_mem_pkg;

  localparam int SIMPLEZ_AW = 9;
  localparam int SIMPLEZ_DW = 12;

  localparam logic CPU    = 1'b0;
  localparam logic LOADER = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/simplez_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; the last-grant pointer is owned by the parent.
module rr_arbiter2
  import simplez_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = enable_i & (|req_i);
    winner_o = CPU;
    if (req_i == 2'b11) begin
      winner_o = ~last_i;
    end else if (req_i[1]) begin
      winner_o = LOADER;
    end
  end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// CPU / loader access controller for the single-ported Simplez 512x12 memory.
module simplez_mem_arbiter
  import simplez_mem_pkg::*;
#(
  parameter int AW = SIMPLEZ_AW,
  parameter int DW = SIMPLEZ_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          grant
);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic arb_winner;
  logic arb_valid;

  rr_arbiter2 u_rr (
    .req_i    ({m1_req, m0_req}),
    .enable_i (state_q == IDLE),
    .last_i   (ptr_q),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= LOADER;
      grant_q    <= CPU;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      mem_din_q  <= '0;
      ack_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q   <= mem_wr_d;
      mem_din_q  <= mem_din_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mem_addr_d = mem_addr_q;
    mem_wr_d   = 1'b0;
    mem_din_d  = mem_din_q;
    ack_d      = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (arb_winner == LOADER) begin
            mem_addr_d = m1_addr;
            mem_wr_d   = m1_wr;
            mem_din_d  = m1_wdata;
          end else begin
            mem_addr_d = m0_addr;
            mem_wr_d   = m0_wr;
            mem_din_d  = m0_wdata;
          end
          grant_d = arb_winner;
          ptr_d   = arb_winner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Memory has acted on the falling edge; on writes mem_dout is the old word.
        if (grant_q == LOADER) begin
          rdata1_d = mem_dout;
        end else begin
          rdata0_d = mem_dout;
        end
        ack_d[grant_q] = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr = mem_addr_q;
  assign mem_wr   = mem_wr_q;
  assign mem_din  = mem_din_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign busy     = (state_q != IDLE);
  assign grant    = grant_q;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Bench for simplez_mem_arbiter: falling-edge memory model plus a transaction-level reference.
module tb_simplez_mem_arbiter;
  import simplez_mem_pkg::*;

  localparam int AW = SIMPLEZ_AW;
  localparam int DW = SIMPLEZ_DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_req, m1_req, m0_wr, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          busy, grant;

  always #5 clk = ~clk;

  simplez_mem_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy),
    .grant    (grant)
  );

  // Memory environment: read-before-write on the falling edge.
  logic [DW-1:0] mem [512];
  always @(negedge clk) begin
    mem_dout <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit            pend [2];
  bit            pw   [2];
  logic [AW-1:0] pa   [2];
  logic [DW-1:0] pd   [2];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] exp_rd [2];
  int            last_g;
  int            ack_at [2];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int p);
    return (p == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic drive();
    m0_req = pend[0]; m0_wr = pw[0]; m0_addr = pa[0]; m0_wdata = pd[0];
    m1_req = pend[1]; m1_wr = pw[1]; m1_addr = pa[1]; m1_wdata = pd[1];
  endtask

  task automatic post(input int p, input bit wr, input int addr, input int data);
    pend[p] = 1'b1;
    pw[p]   = wr;
    pa[p]   = AW'(addr);
    pd[p]   = DW'(data);
  endtask

  task automatic model_reset();
    last_g    = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_mem_wr"},   32'(mem_wr),   32'(0));
    chk({tag, "_mem_din"},  32'(mem_din),  32'(0));
    chk({tag, "_ack0"},     32'(m0_ack),   32'(0));
    chk({tag, "_ack1"},     32'(m1_ack),   32'(0));
    chk({tag, "_rd0"},      32'(m0_rdata), 32'(0));
    chk({tag, "_rd1"},      32'(m1_rdata), 32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_grant"},    32'(grant),    32'(0));
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_busy"},  32'(busy),   32'(0));
    chk({tag, "_wr"},    32'(mem_wr), 32'(0));
    chk({tag, "_acks"},  32'({m1_ack, m0_ack}), 32'(0));
  endtask

  // One arbitration round: sample edge, ACCESS, RESP; the next edge may grant again.
  task automatic round(input bit drop_early, output int obs_grant);
    int w;
    drive();
    if (pend[0] && pend[1]) w = 1 - last_g;
    else                    w = pend[0] ? 0 : 1;
    @(posedge clk); #1;
    obs_grant = int'(grant);
    chk("acc_busy",  32'(busy),   32'(1));
    chk("acc_grant", 32'(grant),  32'(w));
    chk("acc_wr",    32'(mem_wr), 32'(pw[w]));
    chk("acc_addr",  32'(mem_addr), 32'(pa[w]));
    if (pw[w]) chk("acc_din", 32'(mem_din), 32'(pd[w]));
    chk("acc_acks",  32'({m1_ack, m0_ack}), 32'(0));
    if (drop_early) begin
      if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("resp_ack_w",   32'(ack_of(w)),     32'(1));
    chk("resp_ack_o",   32'(ack_of(1 - w)), 32'(0));
    chk("resp_rd_w",    32'(rd_of(w)),      32'(ref_mem[pa[w]]));
    chk("resp_rd_o",    32'(rd_of(1 - w)),  32'(exp_rd[1 - w]));
    chk("resp_wr_low",  32'(mem_wr),        32'(0));
    chk("resp_busy",    32'(busy),          32'(1));
    exp_rd[w] = ref_mem[pa[w]];
    if (pw[w]) ref_mem[pa[w]] = pd[w];
    last_g    = w;
    ack_at[w] = cyc;
    pend[w]   = 1'b0;
    drive();
    @(posedge clk); #1;
    chk("post_acks", 32'({m1_ack, m0_ack}), 32'(0));
    chk("post_busy", 32'(busy),     32'(0));
    chk("post_rd_w", 32'(rd_of(w)), 32'(exp_rd[w]));
  endtask

  initial begin
    int g;
    int prev;
    rstn = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    pw[0] = 1'b0; pw[1] = 1'b0;
    pa[0] = '0; pa[1] = '0;
    pd[0] = '0; pd[1] = '0;
    drive();
    for (int i = 0; i < 512; i++) begin
      mem[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end
    mem[2]     = 12'o7002;
    ref_mem[2] = 12'o7002;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rstn = 1'b1;
    check_idle("idle0");

    // Port 0 write, then read of a preloaded word
    post(0, 1'b1, 9'o001, 12'o7000);
    round(1'b0, g);
    chk("t1_mem1", 32'(mem[1]), 32'(12'o7000));
    post(0, 1'b0, 9'o002, 0);
    round(1'b0, g);
    check_idle("t2_idle");
    chk("t2_rd_hold", 32'(m0_rdata), 32'(12'o7002));

    // Contention straight after reset: grants 0,1,0 with both reqs held
    rstn = 1'b0; #1; rstn = 1'b1;
    model_reset();
    post(0, 1'b0, 9'o003, 0);
    post(1, 1'b1, 9'o004, 12'o1234);
    round(1'b0, g);
    chk("t3_g0", 32'(g), 32'(0));
    post(0, 1'b0, 9'o003, 0);
    round(1'b0, g);
    chk("t3_g1", 32'(g), 32'(1));
    round(1'b0, g);
    chk("t3_g2", 32'(g), 32'(0));
    chk("t3_mem4", 32'(mem[4]),   32'(12'o1234));
    chk("t3_rd0",  32'(m0_rdata), 32'(12'o0003));

    // Port 1 back-to-back writes, ack spacing, read-back through port 0
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      post(1, 1'b1, 9'o010 + i, 12'o4400 + 11 * i);
      round(1'b0, g);
      if (i > 0) chk("t4_spacing", 32'(ack_at[1] - prev), 32'(3));
      prev = ack_at[1];
    end
    for (int i = 0; i < 4; i++) begin
      post(0, 1'b0, 9'o010 + i, 0);
      round(1'b0, g);
      chk("t4_readback", 32'(m0_rdata), 32'(12'o4400 + 11 * i));
    end

    // Request withdrawn during ACCESS still completes exactly once
    post(0, 1'b0, 9'o005, 0);
    round(1'b1, g);
    check_idle("t5_idle_a");
    check_idle("t5_idle_b");

    // Reset in the ACCESS cycle of a write
    post(0, 1'b1, 9'o006, 12'o5555);
    drive();
    @(posedge clk); #1;
    chk("t6_wr_high", 32'(mem_wr), 32'(1));
    rstn = 1'b0;
    #1;
    chk_reset("t6_async");
    pend[0] = 1'b0;
    drive();
    @(posedge clk); #1;
    chk_reset("t6_held");
    rstn = 1'b1;
    model_reset();
    check_idle("t6_idle");
    chk("t6_mem6", 32'(mem[6]), 32'(ref_mem[6]));
    post(0, 1'b0, 9'o007, 0);
    post(1, 1'b0, 9'o010, 0);
    round(1'b0, g);
    chk("t6_first_tie", 32'(g), 32'(0));
    round(1'b0, g);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1))
          post(p, 1'($urandom_range(0, 1)), $urandom_range(0, 15), int'($urandom & 32'hFFF));
      end
      if (!pend[0] && !pend[1])
        post($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
             int'($urandom & 32'hFFF));
      round(1'b0, g);
    end
    while (pend[0] || pend[1]) round(1'b0, g);
    for (int a = 0; a < 16; a++) chk("rand_mem", 32'(mem[a]), 32'(ref_mem[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/simplez_mem_arbiter.md
# simplez_mem_arbiter

Two-port access controller in front of the Simplez 512×12 program/data memory, letting the CPU and a program loader/debug port share that single-ported memory. Each requester uses a level req / single-cycle ack handshake. The block registers the memory address, write strobe and write data, returns read data, and round-robins between requesters on contention. The memory samples on the falling clock edge, so each access completes within one arbiter cycle.

## Interface
- AW, 9, memory address width (512 words)
- DW, 12, memory data width
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request, level; port 0 = CPU, port 1 = loader
- m0_wr / m1_wr  in  1  1 = write, 0 = read; qualified by req
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DW  read data, valid from ack until that port's next ack
- mem_addr  out  AW  to memory addr
- mem_wr  out  1  to memory wr
- mem_din  out  DW  to memory data_in
- mem_dout  in  DW  from memory data_out
- busy  out  1  high in ACCESS and RESP
- grant  out  1  port owning the current or last access

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner, register mem_addr, mem_wr and mem_din from the winner, set grant, and go to ACCESS.
  - With no req, hold mem_wr = 0 and stay in IDLE.
- ACCESS:
  - mem_wr is high for this cycle only, and only for writes.
  - The memory performs the operation on the mid-cycle falling edge.
  - At the next rising edge: capture mem_dout into the granted port's rdata, even on writes (the memory returns the old word), clear mem_wr, pulse that port's ack, and go to RESP.
- RESP:
  - ack is high for this cycle only.
  - req is not sampled.
  - Go to IDLE.
- Arbitration:
  - 2-way round-robin with a last-grant pointer.
  - On a tie, the port not granted last wins.
  - The pointer resets to 1, so port 0 wins the first tie.
  - A sole requester always wins.
- Protocol:
  - The requester holds req, wr, addr and wdata stable until it samples ack.
  - The requester drops req the cycle after ack unless it wants another access.
  - If req drops during ACCESS, the access still completes and ack still pulses.
- The non-granted port's rdata and ack are untouched.

## Timing
- Reset values: state IDLE, mem_addr 0, mem_wr 0, mem_din 0, m0/m1_ack 0, m0/m1_rdata 0, busy 0, grant 0, pointer 1.
- Reset asserted mid-access aborts the access: mem_wr falls immediately and no ack is issued.
- Cycle timing:
  - Cycle 0: req sampled.
  - Cycle 1: ACCESS.
  - Cycle 2: RESP, ack high.
  - Cycle 3: earliest next grant.
- Latency is 2 cycles from req-sample edge to ack-visible edge; throughput is 1 access per 3 cycles.
- A continuously held req on both ports alternates grants 0,1,0,1…
- Width rules:
  - Addresses pass through unmodified; no wrap logic is needed because AW spans the whole memory.
  - rdata is a straight DW-bit capture.

## Structure
- Package simplez_mem_pkg holds:
  - AW and DW defaults
  - the state encoding (IDLE, ACCESS, RESP)
  - port index constants CPU = 0, LOADER = 1
- Sub-module rr_arbiter2: inputs req[1:0], enable and the last-grant pointer; outputs winner and valid. It is combinational, with the pointer register living in the parent.
- Expected size: about 150–250 lines of RTL.

## Test plan
- Reset, then port 0 writes 12'o7000 to addr 9'o001 → mem_wr is high for exactly one cycle with mem_addr 9'o001; m0_ack pulses 2 cycles after the req edge.
- Port 0 reads addr 9'o002 preloaded with 12'o7002 → m0_rdata = 12'o7002 when m0_ack is high, and it holds that value afterwards.
- Both ports request from the same edge (m0 reads 9'o003, m1 writes 12'o1234 to 9'o004), then hold req → grant sequence is 0,1,0; m1's write lands, and m0_rdata stays 12'o0003.
- Port 1 alone issues 4 back-to-back writes to 9'o010–9'o013 → each m1_ack is spaced exactly 3 cycles apart; read-back via port 0 matches.
- Port 0 drops req in the ACCESS cycle → m0_ack still pulses once, and no second access starts.
- rstn pulled low in the ACCESS cycle of a write → mem_wr falls immediately, no ack, and all outputs are at reset values; after rstn rises, the first tie goes to port 0.
